// File: rtl/delayline_mc_if.sv
// Sample/flag bundle for the multi-channel delay line: producer drives ce,
// latency and in; the delay line returns the re-timed samples and status flags.
interface delayline_mc_if #(
  parameter int CHANNELS  = 3,
  parameter int BIT_WIDTH = 8,
  parameter int SIZE      = 5
);
  localparam int W = CHANNELS * BIT_WIDTH;

  logic            ce;
  logic [SIZE-1:0] latency;
  logic [W-1:0]    in;
  logic [W-1:0]    out;
  logic            out_valid;
  logic            lat_changed;

  modport master (
    output ce, latency, in,
    input  out, out_valid, lat_changed
  );

  modport slave (
    input  ce, latency, in,
    output out, out_valid, lat_changed
  );
endinterface

// File: rtl/delayline_mc.sv
// Multi-channel, clock-enabled delay line with one shared programmable latency.
// Channels share pointers and flags; data is stored as one packed word per slot.
module delayline_mc #(
  parameter int CHANNELS  = 3,
  parameter int BIT_WIDTH = 8,
  parameter int SIZE      = 5
) (
  input logic            clk,
  input logic            rst_n,
  delayline_mc_if.slave  bus
);
  localparam int              W        = CHANNELS * BIT_WIDTH;
  localparam int              DEPTH    = 1 << SIZE;
  localparam logic [SIZE-1:0] FILL_MAX = '1;

  logic [W-1:0]    mem [DEPTH];

  logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE-1:0] fill_cnt_q, fill_cnt_d;
  logic [SIZE-1:0] l_cur_q, l_cur_d;
  logic [SIZE-1:0] l_prev_q, l_prev_d;
  logic [W-1:0]    out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            lat_changed_q, lat_changed_d;
  logic [SIZE-1:0] rd_ptr;

  // Modulo-2^SIZE subtraction; l_cur>0 never aliases the slot being written.
  assign rd_ptr = wr_ptr_q - l_cur_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    l_cur_d       = l_cur_q;
    l_prev_d      = l_prev_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    lat_changed_d = lat_changed_q;
    if (bus.ce) begin
      wr_ptr_d      = wr_ptr_q + SIZE'(1);
      fill_cnt_d    = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + SIZE'(1);
      l_cur_d       = bus.latency;
      l_prev_d      = l_cur_q;
      out_d         = (l_cur_q == '0) ? bus.in : mem[rd_ptr];
      out_valid_d   = (l_cur_q == '0) || (fill_cnt_q >= l_cur_q);
      lat_changed_d = (l_cur_q != l_prev_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      l_cur_q       <= '0;
      l_prev_q      <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      lat_changed_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      l_cur_q       <= l_cur_d;
      l_prev_q      <= l_prev_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      lat_changed_q <= lat_changed_d;
    end
  end

  // NOTE: the sample memory has no reset; stale slots are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (bus.ce) mem[wr_ptr_q] <= bus.in;
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.lat_changed = lat_changed_q;
endmodule

// File: tb/tb_delayline_mc.sv
// Scoreboard bench for delayline_mc: stimulus pushes expected outputs from an
// input-history model; an independent monitor pops and compares after each edge.
module tb_delayline_mc;
  localparam int CH = 3;
  localparam int BW = 8;
  localparam int SZ = 5;
  localparam int W  = CH * BW;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
    logic         lc;
    logic         chk;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  delayline_mc_if #(.CHANNELS(CH), .BIT_WIDTH(BW), .SIZE(SZ)) bus ();

  delayline_mc #(.CHANNELS(CH), .BIT_WIDTH(BW), .SIZE(SZ)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  exp_t last_exp;

  // Reference model: history of every sample accepted since reset.
  logic [W-1:0]  hist [0:1023];
  int            m_n;
  logic [SZ-1:0] m_lcur;
  logic [SZ-1:0] m_lprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ramp(input int n);
    logic [W-1:0] r;
    for (int k = 0; k < CH; k++) r[k*BW +: BW] = BW'(n + 16 * k);
    return r;
  endfunction

  task automatic step(input logic ce_i, input logic [SZ-1:0] lat, input logic [W-1:0] din);
    exp_t e;
    @(negedge clk);
    bus.ce      = ce_i;
    bus.latency = lat;
    bus.in      = din;
    if (ce_i) begin
      e.valid = (m_lcur == '0) || (m_n >= int'(m_lcur));
      e.chk   = e.valid;
      if (m_lcur == '0)  e.data = din;
      else if (e.valid)  e.data = hist[m_n - int'(m_lcur)];
      else               e.data = '0;
      e.lc = (m_lcur != m_lprev);
      exp_q.push_back(e);
      hist[m_n] = din;
      m_n++;
      m_lprev = m_lcur;
      m_lcur  = lat;
    end
  endtask

  // Asserts reset between clock edges and checks the outputs drop at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.ce = 1'b0;
    #1;
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_lat_changed", 32'(bus.lat_changed), 32'd0);
    exp_q.delete();
    m_n = 0;
    m_lcur = '0;
    m_lprev = '0;
    last_exp.data  = '0;
    last_exp.valid = 1'b0;
    last_exp.lc    = 1'b0;
    last_exp.chk   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin : monitor
    logic ce_s;
    logic rst_s;
    exp_t e;
    @(posedge clk);
    ce_s  = bus.ce;
    rst_s = rst_n;
    #1;
    if (rst_s && rst_n) begin
      if (ce_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: DUT advanced with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("out_valid", 32'(bus.out_valid), 32'(e.valid));
          check("lat_changed", 32'(bus.lat_changed), 32'(e.lc));
          if (e.chk) check("out_data", 32'(bus.out), 32'(e.data));
          last_exp = e;
        end
      end else begin
        check("hold_out_valid", 32'(bus.out_valid), 32'(last_exp.valid));
        check("hold_lat_changed", 32'(bus.lat_changed), 32'(last_exp.lc));
        if (last_exp.chk) check("hold_out_data", 32'(bus.out), 32'(last_exp.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce      = 1'b0;
    bus.latency = '0;
    bus.in      = '0;
    #2;
    do_reset();

    // Fill and steady delay, L=3.
    for (int n = 0; n < 12; n++) step(1'b1, 5'd3, ramp(n));

    // Bypass from reset, L=0.
    do_reset();
    for (int n = 0; n < 6; n++) step(1'b1, 5'd0, ramp(100 + n));

    // ce gating, L=2: input keeps moving on ce=0 cycles but must be ignored.
    do_reset();
    for (int i = 0; i < 14; i++) step(i % 2 == 0, 5'd2, ramp(40 + i));

    // Live latency change after fill, then changes on every ce-cycle.
    do_reset();
    for (int n = 0; n < 40; n++) step(1'b1, 5'd4, ramp(n));
    for (int n = 40; n < 52; n++) step(1'b1, 5'd1, ramp(n));
    begin
      logic [SZ-1:0] lat_tab [6];
      lat_tab = '{5'd3, 5'd0, 5'd7, 5'd2, 5'd31, 5'd1};
      for (int i = 0; i < 6; i++) step(1'b1, lat_tab[i], ramp(52 + i));
    end
    for (int n = 58; n < 68; n++) step(1'b1, 5'd5, ramp(n));

    // Max depth with pointer wrap, L=31.
    do_reset();
    for (int n = 0; n < 100; n++) step(1'b1, 5'd31, ramp(n));

    // Async reset mid-stream during an L=4 ramp, then refill.
    do_reset();
    for (int n = 0; n < 10; n++) step(1'b1, 5'd4, ramp(n));
    do_reset();
    for (int n = 0; n < 10; n++) step(1'b1, 5'd4, ramp(200 + n));

    @(posedge clk);
    #2;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
